// File: rtl/add_pkg.sv
// add_pkg: shared slice width and sequencer state encoding for the wide adder
package add_pkg;
    localparam int SLICE_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} add_seq_state_t;
endpackage

// File: rtl/add16.sv
// add16: 16-bit slice adder with carry in and carry out
module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = a + b + cin;
endmodule

// File: rtl/add_seq_wide.sv
// add_seq_wide: multi-cycle wide adder streaming one 16-bit slice per cycle through add16
module add_seq_wide
    import add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     cout
);
    localparam int W  = SLICE_W * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;

    add_seq_state_t      state, next;
    logic [W-1:0]        a_sh, b_sh;
    logic                carry;
    logic [IW-1:0]       idx;
    logic [SLICE_W-1:0]  s16;
    logic                c16;
    logic                last;

    assign last = idx == IW'(WORDS - 1);

    add16 u_add16 (
        .a   (a_sh[SLICE_W-1:0]),
        .b   (b_sh[SLICE_W-1:0]),
        .cin (carry),
        .sum (s16),
        .cout(c16)
    );

    // state register; reset aborts any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // next-state and handshake outputs; in_ready is masked while reset is held
    always_comb begin
        next      = state;
        in_ready  = (state == IDLE) && !reset;
        out_valid = state == DONE;
        unique case (state)
            IDLE:    next = in_valid ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    // operand capture, slice shifting, carry chaining and result assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*SLICE_W +: SLICE_W] <= s16;
            carry <= c16;
            a_sh  <= a_sh >> SLICE_W;
            b_sh  <= b_sh >> SLICE_W;
            idx   <= idx + 1'b1;
            if (last) cout <= c16;
        end
    end
endmodule

// File: tb/tb_add_seq_wide.sv
// tb_add_seq_wide: directed self-checking bench for add_seq_wide (WORDS=4 and WORDS=1)
module tb_add_seq_wide;
    logic        clk = 0;
    logic        reset;
    logic        in_valid, out_ready, cin;
    logic [63:0] a, b;
    logic        in_ready, out_valid, cout;
    logic [63:0] sum;
    logic        in_valid1, out_ready1, cin1;
    logic [15:0] a1, b1;
    logic        in_ready1, out_valid1, cout1;
    logic [15:0] sum1;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;

    always #5 clk = ~clk;

    add_seq_wide #(.WORDS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    add_seq_wide #(.WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input string tag, input logic [63:0] av, input logic [63:0] bv, input logic cv);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        a = av; b = bv; cin = cv; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        a = 64'hDEAD_BEEF_CAFE_F00D; b = 64'h0123_4567_89AB_CDEF; cin = ~cv;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
    endtask

    task automatic finish_op(input string tag, input logic [63:0] es, input logic ec);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, "_released"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        reset = 1; in_valid = 0; out_ready = 0; cin = 0; a = 0; b = 0;
        in_valid1 = 0; out_ready1 = 0; cin1 = 0; a1 = 0; b1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        reset = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        start_op("add5", 64'h5, 64'h5, 0);
        finish_op("add5", 64'hA, 0);

        start_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        finish_op("ripple", 64'h0, 1);

        start_op("cross32", 64'h0000_0000_FFFF_FFFF, 64'h1, 0);
        finish_op("cross32", 64'h0000_0001_0000_0000, 0);

        start_op("msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
        finish_op("msb", 64'h0, 1);

        start_op("bp", 64'h3, 64'h4, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); a = 64'h1111; b = 64'h2222; cin = 1;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, 64'h7);
            chk("bp_cout", cout, 0);
        end
        in_valid = 0;
        finish_op("bp", 64'h7, 0);
        start_op("after_bp", 64'h10, 64'h20, 1);
        finish_op("after_bp", 64'h31, 0);

        start_op("seq_far", 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 0);
        finish_op("seq_far", 64'h0000_0001_0000_0000, 1);

        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        reset = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        chk("midrst_never_valid", lat, 0);
        chk("midrst_idle", in_ready, 1);
        start_op("post_rst", 64'h1234, 64'h1, 1);
        finish_op("post_rst", 64'h1236, 0);

        @(negedge clk);
        a1 = 16'hFFFF; b1 = 16'h0; cin1 = 1; in_valid1 = 1;
        chk("w1_in_ready", in_ready1, 1);
        @(negedge clk);
        in_valid1 = 0;
        chk("w1_run_not_valid", out_valid1, 0);
        @(negedge clk);
        chk("w1_out_valid", out_valid1, 1);
        chk("w1_sum", sum1, 16'h0);
        chk("w1_cout", cout1, 1);
        out_ready1 = 1;
        @(negedge clk);
        out_ready1 = 0;
        chk("w1_released", in_ready1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
